// File: rtl/cacheline_adapter.sv
// cacheline_adapter
//   Responder for the cache's downward-facing port (dfp). It takes one
//   256-bit line read or write at a time and runs it as a BEATS-long burst
//   on the burst memory port (bmem).
//   - Reads: the beats are assembled into a line buffer. The finished line
//     is copied into dfp_rdata when the last beat arrives, and dfp_resp
//     then pulses for one cycle.
//   - Writes: the latched line is sent as consecutive beats. Beat 0 waits
//     for bmem_ready. The remaining beats follow back to back.
// Ports
//   clk, rst (async, active-low)
//   dfp_addr/dfp_read/dfp_write/dfp_wdata : line request from the cache
//   dfp_rdata/dfp_resp                    : read line and completion pulse
//   bmem_addr/bmem_read/bmem_write/bmem_wdata : burst command and write beats
//   bmem_ready/bmem_rdata/bmem_rvalid     : burst accept and read beats
module cacheline_adapter #(
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        dfp_addr,
  input  logic               dfp_read,
  input  logic               dfp_write,
  input  logic [255:0]       dfp_wdata,
  output logic [255:0]       dfp_rdata,
  output logic               dfp_resp,
  output logic [31:0]        bmem_addr,
  output logic               bmem_read,
  output logic               bmem_write,
  output logic [BURST_W-1:0] bmem_wdata,
  input  logic               bmem_ready,
  input  logic [BURST_W-1:0] bmem_rdata,
  input  logic               bmem_rvalid
);

  localparam int LINE_W = 256;
  localparam int BEATS  = LINE_W / BURST_W;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_BURST,
    RESP
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [31:5]        line_addr;
  logic [LINE_W-1:0]  line_buf;
  logic [LINE_W-1:0]  line_merged;
  logic               wr_adv;
  logic               unused_addr_lsb;

  assign unused_addr_lsb = ^dfp_addr[4:0];

  // Beat 0 waits for bmem_ready. Later beats advance every cycle.
  assign wr_adv = (cnt != '0) || bmem_ready;

  // The line buffer with the incoming read beat in place. It feeds both the
  // buffer and dfp_rdata, so the last beat lands in dfp_rdata in one step.
  always_comb begin
    line_merged = line_buf;
    line_merged[cnt*BURST_W +: BURST_W] = bmem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (dfp_write)     state_next = WR_BURST;
        else if (dfp_read) state_next = RD_REQ;
      end
      RD_REQ:   if (bmem_ready) state_next = RD_WAIT;
      RD_WAIT:  if (bmem_rvalid && cnt == LAST) state_next = RESP;
      WR_BURST: if (wr_adv && cnt == LAST) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      line_addr <= '0;
      line_buf  <= '0;
      dfp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (dfp_write) begin
            line_addr <= dfp_addr[31:5];
            line_buf  <= dfp_wdata;
            cnt       <= '0;
          end else if (dfp_read) begin
            line_addr <= dfp_addr[31:5];
            cnt       <= '0;
          end
        end
        RD_WAIT: begin
          if (bmem_rvalid) begin
            line_buf <= line_merged;
            cnt      <= cnt + 1'b1;
            // dfp_rdata changes only when a read completes.
            // A partial or aborted read leaves it untouched.
            if (cnt == LAST) dfp_rdata <= line_merged;
          end
        end
        WR_BURST: if (wr_adv) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bmem_read  = (state == RD_REQ);
    bmem_write = (state == WR_BURST);
    dfp_resp   = (state == RESP);
    bmem_addr  = '0;
    bmem_wdata = '0;
    if (state == RD_REQ || state == RD_WAIT || state == WR_BURST)
      bmem_addr = {line_addr, 5'b0};
    if (state == WR_BURST)
      bmem_wdata = line_buf[cnt*BURST_W +: BURST_W];
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Testbench for cacheline_adapter.
// A table of line transactions is run back to back, and each one's outputs
// are checked cycle by cycle. The expected read line and the expected
// dfp_resp cycle go into a scoreboard queue when the request is driven, and
// they are popped when dfp_resp appears. Hand-written sequences cover reset
// with toggling inputs and reset in the middle of a read.
module tb_cacheline_adapter;
  localparam int BW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   dfp_addr = '0;
  logic          dfp_read = 1'b0, dfp_write = 1'b0;
  logic [255:0]  dfp_wdata = '0;
  logic [255:0]  dfp_rdata;
  logic          dfp_resp;
  logic [31:0]   bmem_addr;
  logic          bmem_read, bmem_write;
  logic [BW-1:0] bmem_wdata;
  logic          bmem_ready = 1'b0;
  logic [BW-1:0] bmem_rdata = '0;
  logic          bmem_rvalid = 1'b0;

  cacheline_adapter #(.BURST_W(BW)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [255:0] rdata;
    int           resp_cyc;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit            rd;
    bit            wr;
    logic [31:0]   addr;
    logic [255:0]  wline;
    logic [255:0]  rline;    // read beats, beat k in [k*64 +: 64]
    int            rdy_dly;  // cycles of bmem_ready low before acceptance
    logic [3:0][3:0] gap;    // idle cycles before each read beat
    bit            stray;    // drive junk rvalid beats outside RD_WAIT
  } vec_t;

  vec_t         vt[7];
  logic [255:0] last_rdata = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rd, bit wr, logic [31:0] a, logic [255:0] wl,
                              logic [255:0] rl, int rdy, logic [15:0] g, bit s);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wline = wl; v.rline = rl;
    v.rdy_dly = rdy; v.gap = g; v.stray = s;
    return v;
  endfunction

  // Starts at posedge+1 of cycle 0 and returns at posedge+1 of the cycle
  // after dfp_resp, so that the next call is a back-to-back request.
  task automatic run_txn(input vec_t v, input string tag);
    int R, resp_c;
    int bc[4];
    bit is_wr, done;
    logic [31:0] al;
    exp_t e, got;
    is_wr = v.wr;
    al = {v.addr[31:5], 5'b0};
    R = 1 + v.rdy_dly;
    bc[0] = R + 1 + int'(v.gap[0]);
    for (int k = 1; k < 4; k++) bc[k] = bc[k-1] + 1 + int'(v.gap[k]);
    resp_c = is_wr ? R + 4 : bc[3] + 1;
    e.rdata = is_wr ? last_rdata : v.rline;
    e.resp_cyc = resp_c;
    sb.push_back(e);
    done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      logic          e_rd, e_wr;
      logic [BW-1:0] e_wd;
      logic [31:0]   e_ad;
      int            bidx;
      dfp_read = v.rd; dfp_write = v.wr; dfp_addr = v.addr; dfp_wdata = v.wline;
      // Ready pulses only in the accept cycle: write beats 1..3 must not wait for it.
      bmem_ready = (c == R);
      bidx = -1;
      if (!is_wr) for (int k = 0; k < 4; k++) if (c == bc[k]) bidx = k;
      if (bidx >= 0) begin
        bmem_rvalid = 1'b1; bmem_rdata = v.rline[bidx*BW +: BW];
      end else if (v.stray && (is_wr || c <= R || c > bc[3])) begin
        bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
      end else begin
        bmem_rvalid = 1'b0; bmem_rdata = '0;
      end
      if (is_wr) begin
        e_rd = 1'b0;
        e_wr = (c >= 1 && c <= R + 3);
        e_wd = '0;
        if (e_wr) e_wd = (c <= R) ? v.wline[BW-1:0] : v.wline[(c-R)*BW +: BW];
        e_ad = e_wr ? al : 32'h0;
      end else begin
        e_rd = (c >= 1 && c <= R);
        e_wr = 1'b0;
        e_wd = '0;
        e_ad = (c >= 1 && c <= bc[3]) ? al : 32'h0;
      end
      @(negedge clk);
      chk($sformatf("%s c%0d bmem_read", tag, c), 256'(bmem_read), 256'(e_rd));
      chk($sformatf("%s c%0d bmem_write", tag, c), 256'(bmem_write), 256'(e_wr));
      chk($sformatf("%s c%0d bmem_wdata", tag, c), 256'(bmem_wdata), 256'(e_wd));
      chk($sformatf("%s c%0d bmem_addr", tag, c), 256'(bmem_addr), 256'(e_ad));
      if (dfp_resp) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL %s c%0d dfp_resp: got 1 expected no response pending", tag, c);
        end else begin
          got = sb.pop_front();
          chk($sformatf("%s resp_cycle", tag), 256'(c), 256'(got.resp_cyc));
          chk($sformatf("%s dfp_rdata", tag), dfp_rdata, got.rdata);
          last_rdata = got.rdata;
        end
        done = 1'b1;
      end else begin
        chk($sformatf("%s c%0d dfp_rdata_hold", tag, c), dfp_rdata, last_rdata);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: got no dfp_resp expected one in cycle %0d", tag, resp_c);
      sb.delete();
    end
    dfp_read = 1'b0; dfp_write = 1'b0; bmem_ready = 1'b0;
    bmem_rvalid = 1'b0; bmem_rdata = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " dfp_resp"},   256'(dfp_resp),   '0);
    chk({tag, " dfp_rdata"},  dfp_rdata,        '0);
    chk({tag, " bmem_addr"},  256'(bmem_addr),  '0);
    chk({tag, " bmem_read"},  256'(bmem_read),  '0);
    chk({tag, " bmem_write"}, 256'(bmem_write), '0);
    chk({tag, " bmem_wdata"}, 256'(bmem_wdata), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] l44, lD, lB, lN, lR;
    l44 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    lD  = {64'hD3D3_0003_0303_D3D3, 64'hD2D2_0002_0202_D2D2,
           64'hD1D1_0001_0101_D1D1, 64'hD0D0_0000_0000_D0D0};
    lB  = {64'hB3, 64'hB2, 64'hB1, 64'hB0} | {4{64'hBEEF_0000_0000_0000}};
    lN  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
           64'hA5A5_5A5A_A5A5_5A5A, 64'h0F0F_F0F0_0F0F_F0F0};
    lR  = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
           64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};

    vt[0] = mk(1, 0, 32'h1234_567C, '0, l44, 0, {4'd2, 4'd0, 4'd1, 4'd0}, 0);
    vt[1] = mk(1, 0, 32'hABCD_0010, '0, lN, 3, 16'h0000, 1);
    vt[2] = mk(0, 1, 32'h0000_1F3F, lD, '0, 2, 16'h0000, 1);
    vt[3] = mk(1, 1, 32'h8000_0020, lB, '0, 0, 16'h0000, 0);
    vt[4] = mk(1, 0, 32'h4444_4440, '0, lR, 0, 16'h0000, 0);
    vt[5] = mk(0, 1, 32'h7777_7777, lN, '0, 0, 16'h0000, 1);
    vt[6] = mk(1, 0, 32'hFFFF_FFFF, '0, lD, 1, {4'd1, 4'd3, 4'd0, 4'd2}, 1);

    // Reset held with toggling inputs: every output stays at zero.
    for (int c = 0; c < 3; c++) begin
      dfp_read = 1'($urandom); dfp_write = 1'($urandom);
      dfp_addr = $urandom; dfp_wdata = {8{$urandom}};
      bmem_ready = 1'($urandom); bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk_all_zero($sformatf("reset c%0d", c));
      @(posedge clk); #1;
    end
    dfp_read = 1'b0; dfp_write = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_txn(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a read, with more beats still arriving.
    dfp_read = 1'b1; dfp_addr = 32'h5555_5540;  // cycle 0
    @(posedge clk); #1;
    bmem_ready = 1'b1;                           // cycle 1
    @(posedge clk); #1;
    bmem_ready = 1'b0; bmem_rvalid = 1'b1; bmem_rdata = 64'hAAAA;  // cycle 2
    @(posedge clk); #1;
    bmem_rdata = 64'hBBBB;                       // cycle 3
    @(posedge clk); #1;
    bmem_rdata = 64'hCCCC;                       // cycle 4
    #2 rst = 1'b0;
    #1 chk_all_zero("midreset async");
    last_rdata = '0;
    dfp_read = 1'b0;
    @(posedge clk); #1;
    bmem_rdata = 64'hDDDD;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bmem_rvalid = (c < 2); bmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk_all_zero($sformatf("post-reset c%0d", c));
      @(posedge clk); #1;
    end
    bmem_rvalid = 1'b0;
    run_txn(mk(1, 0, 32'h5555_5540, '0, lN, 0, {4'd0, 4'd1, 4'd0, 4'd0}, 0), "after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
